// File: rtl/seq_alu_exec.sv
// -----------------------------------------------------------------------------
// seq_alu_exec
//
// Execution unit fed by the ALU control decoder. Handles logic, add/sub,
// branch compares, jump-link and an iterative left shift (one bit per cycle).
// Valid/ready handshake on both issue and result sides; at most one op in
// flight, so peak throughput is one op every two cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   issue request valid
//   in_ready   unit idle and able to accept an issue
//   Operation  4-bit op code from ALU control
//   A, B       operands (A = rs1 or PC, B = rs2 or immediate)
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   Result     registered result
//   Zero       Result == 0, qualified by out_valid
//   Branch     branch/jump taken
//   Illegal    unrecognised op code was accepted
//   busy       an op is in flight
// -----------------------------------------------------------------------------
module seq_alu_exec #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Branch,
  output logic             Illegal,
  output logic             busy
);

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Op codes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b1000;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_JAL = 4'b1110;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_cnt;
  logic             r_branch;
  logic             r_illegal;

  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_branch;
  logic             w_illegal;
  logic             w_is_sll;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;

  assign w_diff   = A - B;
  assign w_lt     = $signed(A) < $signed(B);
  assign w_shamt  = B[SHW-1:0];
  assign w_accept = in_valid && (r_state == IDLE);

  // Single-cycle decode of the issue-side operands. For SLL the operand is
  // only loaded here; the shifting itself happens in the SHIFT state.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    w_res     = '0;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    w_is_sll  = 1'b0;
    case (Operation)
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_ADD: w_res = A + B;
      OP_SUB: w_res = w_diff;
      OP_SLL: begin
        w_res    = A;
        w_is_sll = 1'b1;
      end
      OP_BEQ: begin
        w_res    = w_diff;
        w_branch = (A == B);
      end
      OP_BLT: begin
        w_res    = w_diff;
        w_branch = w_lt;
      end
      OP_BGE: begin
        w_res    = w_diff;
        w_branch = !w_lt;
      end
      OP_JAL: begin
        w_res    = A + WIDTH'(4);
        w_branch = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_cnt     <= '0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_result  <= w_res;
            r_branch  <= w_branch;
            r_illegal <= w_illegal;
            if (w_is_sll) begin
              r_cnt   <= w_shamt;
              r_state <= (w_shamt == '0) ? DONE : SHIFT;
            end else begin
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          r_result <= r_result << 1;
          r_cnt    <= r_cnt - SHW'(1);
          // Last shift happens on the edge where the count reads 1.
          if (r_cnt == SHW'(1)) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign Result    = r_result;
  assign Branch    = r_branch;
  assign Illegal   = r_illegal;
  // Qualified by out_valid so Zero reads 0 out of reset and while shifting.
  assign Zero      = out_valid && (r_result == '0);

endmodule

// File: tb/tb_seq_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_seq_alu_exec
//
// Self-checking bench for seq_alu_exec. Expected results are produced by a
// small behavioural model at issue time, pushed to a queue, and popped and
// compared when the unit raises out_valid.
// -----------------------------------------------------------------------------
module tb_seq_alu_exec;

  localparam int WIDTH = 64;
  localparam int SHW   = 6;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Branch;
  logic             Illegal;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             br;
    logic             ill;
    logic             zero;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_alu_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Branch    (Branch),
    .Illegal   (Illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one operation.
  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    e.res = '0;
    e.br  = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h6: e.res = a - b;
      4'h3: begin
        e.res = a << b[SHW-1:0];
        e.lat = 1 + int'(b[SHW-1:0]);
      end
      4'h5: begin e.res = a - b; e.br = (a == b); end
      4'h8: begin e.res = a - b; e.br = ($signed(a) <  $signed(b)); end
      4'hA: begin e.res = a - b; e.br = ($signed(a) >= $signed(b)); end
      4'hE: begin e.res = a + 64'd4; e.br = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Issue one op, wait for its result, compare against the scoreboard, hold
  // the result under backpressure for 'hold' cycles, then retire it.
  task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold);
    exp_t e;
    int   lat;
    int   guard;
    sb_q.push_back(model(op, a, b));
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("issue_timeout", 1'b0, 1'b1);
      void'(sb_q.pop_front());
      return;
    end
    in_valid  = 1'b1;
    Operation = op;
    A         = a;
    B         = b;
    @(posedge clk);
    #1;
    // Inputs are don't-care after the accept edge; scramble them.
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    A         = {$urandom, $urandom};
    B         = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    check("out_valid", out_valid, 1'b1);
    check("latency",   lat, e.lat);
    check("result",    Result, e.res);
    check("zero",      Zero, e.zero);
    check("branch",    Branch, e.br);
    check("illegal",   Illegal, e.ill);
    check("in_ready_busy", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      // Stray issue attempts while busy must be ignored.
      in_valid  = 1'b1;
      Operation = 4'h0;
      A         = '1;
      B         = '1;
      @(posedge clk);
      #1;
      check("bp_valid",    out_valid, 1'b1);
      check("bp_result",   Result, e.res);
      check("bp_branch",   Branch, e.br);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire_valid", out_valid, 1'b0);
    check("retire_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [3:0]       rop;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit               saw_valid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = '0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    Result, '0);
    check("rst_zero",      Zero, 1'b0);
    check("rst_branch",    Branch, 1'b0);
    check("rst_illegal",   Illegal, 1'b0);
    check("rst_busy",      busy, 1'b0);
    check("rst_in_ready",  in_ready, 1'b1);

    // Reset mid-SLL: in-flight op discarded, no out_valid pulse.
    saw_valid = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'h3;
    A         = 64'd1;
    B         = 64'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      saw_valid |= out_valid;
    end
    check("mid_sll_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2_result",   Result, '0);
    check("rst2_busy",     busy, 1'b0);
    check("rst2_in_ready", in_ready, 1'b1);
    check("rst2_branch",   Branch, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      saw_valid |= out_valid;
    end
    check("rst2_no_valid", saw_valid, 1'b0);
    check("rst2_zero",     Zero, 1'b0);

    // Wrap-around arithmetic
    run_op(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(4'h6, 64'd3, 64'd5, 0);
    // Shift latency, shamt 5 and shamt 0 (upper B bits ignored)
    run_op(4'h3, 64'h1, 64'h45, 0);
    run_op(4'h3, 64'h1, 64'h40, 0);
    run_op(4'h3, 64'h8000_0000_0000_0001, 64'h3F, 0);
    // Signed branches
    run_op(4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(4'h5, 64'd7, 64'd7, 0);
    run_op(4'hA, 64'd7, 64'd7, 0);
    // Jump-link under backpressure
    run_op(4'hE, 64'h1000, 64'h0, 5);
    // Illegal, then logic ops clear the flag
    run_op(4'h7, 64'hF0, 64'h3C, 2);
    run_op(4'h0, 64'hF0, 64'h3C, 0);
    run_op(4'h1, 64'hF0, 64'h3C, 0);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 4 == 0) rb = ra;
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
